// File: rtl/booth4_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// booth4_seq_ctrl_pkg
//   Shared definitions for the sequential radix-4 Booth multiplier:
//     - controller state encodings (IDLE / CALC / DONE)
//     - Booth digit codes and the triplet -> digit decode function
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package booth4_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        DIG_ZERO = 3'd0,
        DIG_P1   = 3'd1,
        DIG_P2   = 3'd2,
        DIG_M1   = 3'd3,
        DIG_M2   = 3'd4
    } digit_t;

    // Radix-4 Booth recoding of {b[2k+1], b[2k], b[2k-1]}.
    function automatic digit_t booth_digit(input logic [2:0] trip);
        digit_t d;
        case (trip)
            3'b001, 3'b010: d = DIG_P1;
            3'b011:         d = DIG_P2;
            3'b100:         d = DIG_M2;
            3'b101, 3'b110: d = DIG_M1;
            default:        d = DIG_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth4_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// booth4_seq_ctrl_if
//   Operand/product handshake bundle for booth4_seq_ctrl.
//   in_valid/in_ready : operand pair A/B transfer (producer -> multiplier)
//   out_valid/out_ready : product S transfer (multiplier -> consumer)
//   master modport : producer/consumer side (testbench or upstream logic)
//   slave modport  : multiplier side
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface booth4_seq_ctrl_if #(
    parameter int TAM = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [TAM-1:0]   A;
    logic signed [TAM-1:0]   B;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [2*TAM-1:0] S;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, S
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, S
    );
endinterface

// File: rtl/booth4_seq_ctrl_digit_sel.sv
// ---------------------------------------------------------------------------
// booth4_digit_sel (combinational)
//   Turns one Booth triplet into the signed partial product 0, +/-A, +/-2A.
//   i_triplet [2:0]     : {b[2k+1], b[2k], b[2k-1]}
//   i_a_ext   [TAM+1:0] : multiplicand sign-extended by two guard bits
//   o_pp      [TAM+1:0] : signed partial product
// The two guard bits let -2*A of the most negative A stay representable.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module booth4_digit_sel
    import booth4_seq_ctrl_pkg::*;
#(
    parameter int TAM = 8
) (
    input  logic        [2:0]     i_triplet,
    input  logic signed [TAM+1:0] i_a_ext,
    output logic signed [TAM+1:0] o_pp
);
    always_comb begin
        o_pp = '0;
        case (booth_digit(i_triplet))
            DIG_P1:  o_pp = i_a_ext;
            DIG_P2:  o_pp = i_a_ext <<< 1;
            DIG_M1:  o_pp = -i_a_ext;
            DIG_M2:  o_pp = -(i_a_ext <<< 1);
            default: o_pp = '0;
        endcase
    end
endmodule

// File: rtl/booth4_seq_ctrl.sv
// ---------------------------------------------------------------------------
// booth4_seq_ctrl
//   Multi-cycle signed radix-4 Booth multiplier. One shared adder retires one
//   Booth digit per clock; a product takes TAM/2 CALC cycles, then waits in
//   DONE until the consumer takes it.
// Ports
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   bus   : booth4_seq_ctrl_if.slave (in_valid/in_ready/A/B, out_valid/out_ready/S)
//   busy  : high in CALC or DONE
//   err   : sticky self-check mismatch flag
// Configuration
//   BOOTH4_SEQ_CHECK_EN : when defined, a behavioural reference product is
//   captured at accept and compared with S in DONE; any mismatch sets err
//   until rst. When undefined err is tied low and no reference logic exists.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module booth4_seq_ctrl
    import booth4_seq_ctrl_pkg::*;
#(
    parameter int TAM = 8
) (
    input  logic              clk,
    input  logic              rst,
    booth4_seq_ctrl_if.slave  bus,
    output logic              busy,
    output logic              err
);
    localparam int NDIG = TAM / 2;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int AW   = 2 * TAM + 2;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic        [CW-1:0]    r_cnt;
    logic signed [TAM+1:0]   r_a_ext;
    logic        [TAM:0]     r_bq;
    logic signed [AW-1:0]    r_acc;
    logic signed [2*TAM-1:0] r_s;

    logic                    w_accept;
    logic                    w_last;
    logic        [2:0]       w_triplet;
    logic signed [TAM+1:0]   w_pp;
    logic signed [AW-1:0]    w_pp_wide;
    logic signed [AW-1:0]    w_acc_nxt;

    assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
    assign w_last    = (r_cnt == CW'(NDIG - 1));
    // {B,1'b0} makes the k-th triplet start at bit 2k.
    assign w_triplet = r_bq[{r_cnt, 1'b0} +: 3];

    booth4_digit_sel #(
        .TAM (TAM)
    ) u_digit_sel (
        .i_triplet (w_triplet),
        .i_a_ext   (r_a_ext),
        .o_pp      (w_pp)
    );

    assign w_pp_wide = {{TAM{w_pp[TAM+1]}}, w_pp};
    assign w_acc_nxt = r_acc + (w_pp_wide <<< {r_cnt, 1'b0});

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)      w_state_nxt = ST_CALC;
            ST_CALC: if (w_last)        w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, digit counter and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a_ext <= '0;
            r_bq    <= '0;
            r_acc   <= '0;
            r_s     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a_ext <= {{2{bus.A[TAM-1]}}, bus.A};
                        r_bq    <= {bus.B, 1'b0};
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_s <= w_acc_nxt[2*TAM-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.S         = r_s;
    assign busy          = (r_state == ST_CALC) || (r_state == ST_DONE);

`ifdef BOOTH4_SEQ_CHECK_EN
    logic signed [2*TAM-1:0] r_ref;
    logic signed [2*TAM-1:0] w_a_wide;
    logic signed [2*TAM-1:0] w_b_wide;
    logic                    r_err;

    assign w_a_wide = {{TAM{bus.A[TAM-1]}}, bus.A};
    assign w_b_wide = {{TAM{bus.B[TAM-1]}}, bus.B};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ref <= w_a_wide * w_b_wide;
            end
            if ((r_state == ST_DONE) && (r_s != r_ref)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_booth4_seq_ctrl.sv
`timescale 1ns/1ps
module tb_booth4_seq_ctrl;
    localparam int TAM = 8;
    localparam int LAT = TAM / 2;

    logic clk;
    logic rst;
    logic busy;
    logic err;

    int n_vec;
    int n_err;

    booth4_seq_ctrl_if #(.TAM(TAM)) bus ();

    booth4_seq_ctrl #(.TAM(TAM)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, wait for the product, hold it for
    // 'stall' cycles with out_ready low, then release it.
    task automatic mul(input logic signed [TAM-1:0] a,
                       input logic signed [TAM-1:0] b,
                       input int stall);
        longint exp;
        int     lat;
        exp = longint'(a) * longint'(b);
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        check("in_ready_at_accept", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        bus.A        = TAM'($urandom);
        bus.B        = TAM'($urandom);
        check("busy_in_calc", busy, 1);
        check("out_valid_in_calc", bus.out_valid, 0);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            step();
            if (bus.out_valid !== 1'b1) lat++;
        end
        check("latency", lat, LAT);
        check("product", $signed(bus.S), exp);
        check("err", err, 0);
        check("in_ready_in_done", bus.in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            step();
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_product", $signed(bus.S), exp);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("out_valid_after_take", bus.out_valid, 0);
        check("in_ready_after_take", bus.in_ready, 1);
        check("product_held_idle", $signed(bus.S), exp);
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_S", $signed(bus.S), 0);
        check("rst_err", err, 0);

        // Basic product and extreme operands
        mul(8'sd3, 8'sd5, 0);
        mul(-8'sd128, -8'sd128, 0);
        mul(8'sd127, -8'sd128, 1);
        mul(8'sd0, -8'sd1, 0);
        mul(-8'sd1, -8'sd1, 0);

        // Stall in DONE with an in_valid pulse that must be ignored
        bus.A        = 8'sd3;
        bus.B        = 8'sd5;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < LAT; i++) step();
        check("stall4_out_valid", bus.out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            bus.A        = 8'sd9;
            bus.B        = 8'sd9;
            bus.in_valid = (i == 1);
            step();
            check("stall4_valid", bus.out_valid, 1);
            check("stall4_S", $signed(bus.S), 15);
            check("stall4_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("stall4_release", bus.out_valid, 0);
        step();
        check("stall4_not_captured", busy, 0);
        check("stall4_S_kept", $signed(bus.S), 15);

        // Reset during the second CALC cycle
        bus.A        = 8'sd11;
        bus.B        = 8'sd3;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_S", $signed(bus.S), 0);
        check("midrst_busy", busy, 0);
        for (int i = 0; i < LAT + 2; i++) begin
            step();
            check("midrst_no_pulse", bus.out_valid, 0);
        end
        mul(-8'sd7, 8'sd6, 0);

        // rst wins over a simultaneous in_valid
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.A        = 8'sd5;
        bus.B        = 8'sd5;
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_vs_valid_busy", busy, 0);
        check("rst_vs_valid_ready", bus.in_ready, 1);
        step();
        check("rst_vs_valid_busy2", busy, 0);

        // Random signed pairs with random consumer stalls
        for (int n = 0; n < 1000; n++) begin
            mul(TAM'($urandom), TAM'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
